// File: rtl/ens_vote_argmax.sv
// Ensemble vote output stage: sums per-class member scores over N_ENS beats, then runs a sequential argmax.
// Optional feature macro ENS_VOTE_SCORE_OUT_EN drives out_score with the winning total (tied to 0 otherwise).
module ens_vote_argmax #(
  parameter  int N_ENS     = 4,
  parameter  int N_CLASSES = 10,
  parameter  int IN_BITS   = 2,
  localparam int ACC_BITS  = IN_BITS + $clog2(N_ENS),
  localparam int IDX_BITS  = $clog2(N_CLASSES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_CLASSES*IN_BITS-1:0]  in_scores,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_BITS-1:0]           out_class,
  output logic [ACC_BITS-1:0]           out_score
);

  localparam int CNT_BITS = (N_ENS > 2) ? $clog2(N_ENS) : 1;
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(N_ENS - 1);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N_CLASSES - 1);

  typedef enum logic [1:0] {ACCUM, ARGMAX, OUTPUT} state_t;

  state_t                state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;
  logic [ACC_BITS-1:0]   best_q, best_d;
  logic [IDX_BITS-1:0]   best_idx_q, best_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic [IDX_BITS-1:0]   out_class_q, out_class_d;
  logic [ACC_BITS-1:0]   acc_q [N_CLASSES];
  logic [ACC_BITS-1:0]   acc_d [N_CLASSES];

  logic [ACC_BITS-1:0]   cand;
  logic                  take;
  logic [ACC_BITS-1:0]   win_score;

  // Index 0 always loads, which preloads best with class 0 on the first argmax cycle.
  assign cand      = acc_q[idx_q];
  assign take      = (idx_q == '0) || (cand > best_q);
  assign win_score = take ? cand : best_q;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    out_valid_d = out_valid_q;
    out_class_d = out_class_q;
    acc_d       = acc_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          for (int c = 0; c < N_CLASSES; c++) begin
            acc_d[c] = acc_q[c] + ACC_BITS'(in_scores[c*IN_BITS +: IN_BITS]);
          end
          if (cnt_q == LAST_CNT) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = ARGMAX;
          end else begin
            cnt_d = cnt_q + CNT_BITS'(1);
          end
        end
      end
      ARGMAX: begin
        if (take) begin
          best_d     = cand;
          best_idx_d = idx_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d     = OUTPUT;
          out_valid_d = 1'b1;
          out_class_d = take ? idx_q : best_idx_q;
        end else begin
          idx_d = idx_q + IDX_BITS'(1);
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
          for (int c = 0; c < N_CLASSES; c++) acc_d[c] = '0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      cnt_q       <= '0;
      idx_q       <= '0;
      best_q      <= '0;
      best_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      for (int c = 0; c < N_CLASSES; c++) acc_q[c] <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      best_q      <= best_d;
      best_idx_q  <= best_idx_d;
      out_valid_q <= out_valid_d;
      out_class_q <= out_class_d;
      for (int c = 0; c < N_CLASSES; c++) acc_q[c] <= acc_d[c];
    end
  end

`ifdef ENS_VOTE_SCORE_OUT_EN
  logic [ACC_BITS-1:0] out_score_q, out_score_d;

  always_comb begin
    out_score_d = out_score_q;
    if (state_q == ARGMAX && idx_q == LAST_IDX) out_score_d = win_score;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_score_q <= '0;
    else        out_score_q <= out_score_d;
  end

  assign out_score = out_score_q;
`else
  assign out_score = '0;
`endif

endmodule
